key_decoder: RTL and testbench
==============================

KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 The module SHALL have this port: clk  input  1  system clock; every register is clocked on its rising edge.
REQ-002 The module SHALL have this port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 The module SHALL have this port: ps2_key  input  11  keyboard event word from hps_io; [10] toggles once per event, [9] 1=press/0=release, [8] E0-extended flag, [7:0] scancode.
REQ-004 The module SHALL have this port: joystick_in  input  32  joystick_0 word from hps_io.
REQ-005 The module SHALL have this port: osd_status  input  1  1 while the OSD is open.
REQ-006 The module SHALL have this port: joy_out  output  32  merged keyboard/joystick word, same bit layout as joystick_0.
REQ-007 The module SHALL have this port: joy_pulse  output  10  one-cycle rising-edge pulse for each of joy_out[9:0].

Function
REQ-008 The bit map SHALL be: [0] right, [1] left, [2] down, [3] up, [4] In, [5] Out, [6] Faster, [7] Slower, [8] Pause, [9] Trails; bits [31:10] are zero.
REQ-009 The key map SHALL be: E0+74 right, E0+6B left, E0+72 down, E0+75 up, 1A (Z) In, 22 (X) Out, 1C (A) Faster, 1B (S) Slower, 5A (Enter) Pause, 29 (Space) Trails; any other code, or a mismatched E0 flag, SHALL be ignored.
REQ-010 ps2_key SHALL be registered once; an event is a difference between registered bit [10] and the stored previous toggle value.
REQ-011 The first registered ps2_key sample after reset SHALL only prime the stored toggle value and SHALL NOT generate an event.
REQ-012 A press event SHALL set the mapped bit in key_state; a release event SHALL clear it; repeated presses (typematic) SHALL be idempotent.
REQ-013 Left/right and up/down SHALL be resolved last-input-priority: while both keys of a pair are held, only the most recently pressed one is asserted.
REQ-014 When the priority key of a pair is released while the other is still held, the other key SHALL reassert on the next cycle.
REQ-015 joy_out SHALL be the registered value of joystick_in OR resolved key_state, and bits [3:0] SHALL never show both keys of a pair set from the keyboard path; a conflict coming from joystick_in SHALL pass through unchanged.
REQ-016 Latency SHALL be 3 clk from a ps2_key toggle to joy_out, and 1 clk from joystick_in to joy_out.
REQ-017 joy_pulse[i] SHALL be 1 for exactly the one cycle in which joy_out[i] goes 0->1, and 0 otherwise.
REQ-018 While osd_status=1, key_state and the SOCD history SHALL be held at zero, events SHALL be consumed (the stored toggle value still updates) without effect, and joystick_in SHALL still pass through.
REQ-019 Toggle events SHALL be handled back-to-back at the rate of one per clk; if an event and a falling edge of osd_status occur in the same cycle, the event SHALL be applied.

Reset
REQ-020 While reset_n=0, joy_out, joy_pulse, key_state, the SOCD history, the registered inputs, and the primed flag SHALL all be 0.
REQ-021 Deassertion of reset_n mid-keypress SHALL leave the key released until a new press event arrives.

Structure
REQ-022 The bit indices, scancode constants, and the KEY_E0 flag position SHALL be defined in the shared package bu_pkg.
REQ-023 The pair arbitration SHALL be the sub-module key_socd, instantiated twice (once for left/right, once for up/down), each with a 2-bit held input, a 2-bit resolved output, and a last-pressed flop.

Verification
REQ-024 The bench SHALL cover: reset with ps2_key[10]=1, then no activity -> joy_out=0 (no spurious event).
REQ-025 The bench SHALL cover: toggle with {press, E0, 0x75} -> joy_out=0x008 three clk later, joy_pulse[3]=1 for one cycle; a release toggle -> joy_out=0x000.
REQ-026 The bench SHALL cover: press left, then press right, then release right -> joy_out sequence 0x002, 0x001, 0x002.
REQ-027 The bench SHALL cover: press 0x5A with joystick_in=0x010 -> joy_out=0x110; press 0x5A without the E0 flag set versus with it set -> only the non-E0 press maps.
REQ-028 The bench SHALL cover: hold Z, then set osd_status=1 -> joy_out=0x000 one clk after key_state clears; a Z release during OSD then OSD close -> joy_out stays 0.
REQ-029 The bench SHALL cover: ten back-to-back toggles on consecutive clk -> all ten events applied in order, with the final state matching the last event of each key.

Source files
------------

// File: rtl/bu_pkg.sv
// Shared key/joystick constants and the scancode-to-bit map.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package bu_pkg;

  localparam int JOY_W    = 32;
  localparam int KEY_BITS = 10;

  // joy_out bit positions (same layout as hps_io joystick_0)
  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_IN     = 4;
  localparam int JOY_OUT    = 5;
  localparam int JOY_FASTER = 6;
  localparam int JOY_SLOWER = 7;
  localparam int JOY_PAUSE  = 8;
  localparam int JOY_TRAILS = 9;

  // ps2_key field positions
  localparam int KEY_TOGGLE = 10;
  localparam int KEY_PRESS  = 9;
  localparam int KEY_E0     = 8;

  // Set-2 scancodes; the four arrows arrive with the E0 prefix
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_Z      = 8'h1A;
  localparam logic [7:0] SC_X      = 8'h22;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_map_t;

  // The E0 flag is part of the match: a plain 0x75 is not "up", E0+0x5A is not Enter.
  function automatic key_map_t map_key(input logic e0, input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b0;
    m.idx = 4'd0;
    case ({e0, code})
      {1'b1, SC_RIGHT}: begin m.hit = 1'b1; m.idx = 4'(JOY_RIGHT);  end
      {1'b1, SC_LEFT }: begin m.hit = 1'b1; m.idx = 4'(JOY_LEFT);   end
      {1'b1, SC_DOWN }: begin m.hit = 1'b1; m.idx = 4'(JOY_DOWN);   end
      {1'b1, SC_UP   }: begin m.hit = 1'b1; m.idx = 4'(JOY_UP);     end
      {1'b0, SC_Z    }: begin m.hit = 1'b1; m.idx = 4'(JOY_IN);     end
      {1'b0, SC_X    }: begin m.hit = 1'b1; m.idx = 4'(JOY_OUT);    end
      {1'b0, SC_A    }: begin m.hit = 1'b1; m.idx = 4'(JOY_FASTER); end
      {1'b0, SC_S    }: begin m.hit = 1'b1; m.idx = 4'(JOY_SLOWER); end
      {1'b0, SC_ENTER}: begin m.hit = 1'b1; m.idx = 4'(JOY_PAUSE);  end
      {1'b0, SC_SPACE}: begin m.hit = 1'b1; m.idx = 4'(JOY_TRAILS); end
      default:          begin m.hit = 1'b0; m.idx = 4'd0;           end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_socd.sv
// Opposing-direction arbiter: while both keys of a pair are held, only the most recent wins.
// Latency: 0 clk from held to resolved (history flops only remember the last press).
// Backpressure: none; held is sampled every cycle.
module key_socd (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic [1:0] held,
  output logic [1:0] resolved
);

  logic [1:0] prev_q, prev_d;
  logic       last_q, last_d;
  logic [1:0] rise;

  // Track which key of the pair went down most recently; resolve with the updated
  // choice so a new press wins in the same cycle it becomes held.
  always_comb begin
    rise     = held & ~prev_q;
    prev_d   = held;
    last_d   = last_q;
    if (rise == 2'b10) begin
      last_d = 1'b1;
    end else if (rise == 2'b01) begin
      last_d = 1'b0;
    end
    if (clr) begin
      prev_d = 2'b00;
      last_d = 1'b0;
    end
    resolved = held;
    if (held == 2'b11) begin
      resolved = last_d ? 2'b10 : 2'b01;
    end
  end

  // Press history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 2'b00;
      last_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/key_decoder.sv
// Maps PS/2 key events onto the joystick_0 bit layout and merges them with the real joystick.
// Latency: 3 clk ps2_key toggle -> joy_out, 1 clk joystick_in -> joy_out.
// Backpressure: none; accepts one key event per clk, events during OSD are consumed silently.
module key_decoder
  import bu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [10:0]       ps2_key,
  input  logic [JOY_W-1:0]  joystick_in,
  input  logic              osd_status,
  output logic [JOY_W-1:0]  joy_out,
  output logic [KEY_BITS-1:0] joy_pulse
);

  logic [10:0]          ps2_q, ps2_d;
  logic                 ps2_vld_q, ps2_vld_d;
  logic                 primed_q, primed_d;
  logic                 tog_q, tog_d;
  logic [KEY_BITS-1:0]  key_state_q, key_state_d;
  logic [JOY_W-1:0]     joy_out_q, joy_out_d;
  logic [KEY_BITS-1:0]  joy_pulse_q, joy_pulse_d;

  key_map_t             km;
  logic                 evt;
  logic [KEY_BITS-1:0]  mask;
  logic [1:0]           lr_res, ud_res;
  logic [KEY_BITS-1:0]  resolved;

  // Left/right pair: held[0]=right, held[1]=left
  key_socd u_socd_lr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (osd_status),
    .held     (key_state_q[JOY_LEFT:JOY_RIGHT]),
    .resolved (lr_res)
  );

  // Up/down pair: held[0]=down, held[1]=up
  key_socd u_socd_ud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (osd_status),
    .held     (key_state_q[JOY_UP:JOY_DOWN]),
    .resolved (ud_res)
  );

  // Event detection, key state update and output merge
  always_comb begin
    ps2_d     = ps2_key;
    ps2_vld_d = 1'b1;
    primed_d  = primed_q;
    tog_d     = tog_q;
    evt       = 1'b0;
    km        = map_key(ps2_q[KEY_E0], ps2_q[7:0]);
    mask      = {{(KEY_BITS-1){1'b0}}, 1'b1} << km.idx;

    // The first valid registered sample only primes the toggle reference, so a
    // key held across reset never produces a phantom event.
    if (ps2_vld_q) begin
      primed_d = 1'b1;
      tog_d    = ps2_q[KEY_TOGGLE];
      evt      = primed_q && (ps2_q[KEY_TOGGLE] != tog_q);
    end

    key_state_d = key_state_q;
    if (osd_status) begin
      key_state_d = '0;
    end else if (evt && km.hit) begin
      key_state_d = ps2_q[KEY_PRESS] ? (key_state_q | mask) : (key_state_q & ~mask);
    end

    resolved    = {key_state_q[KEY_BITS-1:JOY_IN], ud_res, lr_res};
    joy_out_d   = joystick_in | {{(JOY_W-KEY_BITS){1'b0}}, resolved};
    joy_pulse_d = joy_out_d[KEY_BITS-1:0] & ~joy_out_q[KEY_BITS-1:0];
  end

  // Pipeline and state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2_q       <= '0;
      ps2_vld_q   <= 1'b0;
      primed_q    <= 1'b0;
      tog_q       <= 1'b0;
      key_state_q <= '0;
      joy_out_q   <= '0;
      joy_pulse_q <= '0;
    end else begin
      ps2_q       <= ps2_d;
      ps2_vld_q   <= ps2_vld_d;
      primed_q    <= primed_d;
      tog_q       <= tog_d;
      key_state_q <= key_state_d;
      joy_out_q   <= joy_out_d;
      joy_pulse_q <= joy_pulse_d;
    end
  end

  assign joy_out   = joy_out_q;
  assign joy_pulse = joy_pulse_q;

endmodule

// File: tb/tb_key_decoder.sv
// Directed bench for key_decoder with a cycle-stamped scoreboard.
// Stimulus pushes the expected joy_out/joy_pulse for a given cycle; the monitor checks on negedge.
// Runs to completion without backpressure; a watchdog bounds the run.
module tb_key_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joystick_in;
  logic        osd_status;
  logic [31:0] joy_out;
  logic [9:0]  joy_pulse;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] jo;
    logic [9:0]  jp;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        p;
    logic        e0;
    logic [7:0]  code;
    logic [31:0] jo;
    logic [9:0]  jp;
  } vec_t;

  // Ten back-to-back events and the joy_out/joy_pulse each one must produce
  vec_t tbl[10] = '{
    '{1'b1, 1'b0, 8'h1A, 32'h010, 10'h010},  // press Z
    '{1'b1, 1'b0, 8'h22, 32'h030, 10'h020},  // press X
    '{1'b1, 1'b0, 8'h1C, 32'h070, 10'h040},  // press A
    '{1'b1, 1'b0, 8'h1B, 32'h0F0, 10'h080},  // press S
    '{1'b1, 1'b0, 8'h29, 32'h2F0, 10'h200},  // press Space
    '{1'b0, 1'b0, 8'h22, 32'h2D0, 10'h000},  // release X
    '{1'b1, 1'b1, 8'h75, 32'h2D8, 10'h008},  // press up
    '{1'b1, 1'b1, 8'h72, 32'h2D4, 10'h004},  // press down: down wins over up
    '{1'b0, 1'b0, 8'h1A, 32'h2C4, 10'h000},  // release Z
    '{1'b0, 1'b1, 8'h75, 32'h2C4, 10'h000}   // release up: down already shown
  };

  key_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_key     (ps2_key),
    .joystick_in (joystick_in),
    .osd_status  (osd_status),
    .joy_out     (joy_out),
    .joy_pulse   (joy_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int d, input logic [31:0] jo, input logic [9:0] jp);
    exp_t e;
    e.cyc = cyc + d;
    e.jo  = jo;
    e.jp  = jp;
    sb.push_back(e);
  endtask

  task automatic key(input logic p, input logic e0, input logic [7:0] code);
    ps2_key = {~ps2_key[10], p, e0, code};
  endtask

  // Monitor: compare every expectation stamped for the current cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_checks++;
        if (joy_out !== sb[i].jo || joy_pulse !== sb[i].jp) begin
          n_fail++;
          $display("FAIL joy@cyc%0d: got joy_out=%h joy_pulse=%h, want joy_out=%h joy_pulse=%h",
                   cyc, joy_out, joy_pulse, sb[i].jo, sb[i].jp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed@cyc%0d: expectation never sampled (now %0d)", sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    ps2_key     = 11'h400;
    joystick_in = 32'h0;
    osd_status  = 1'b0;

    // Reset with toggle bit high, then idle: no spurious event
    step();
    step();
    expect_at(0, 32'h0, 10'h0);
    step();
    reset_n = 1'b1;
    repeat (6) begin
      step();
      expect_at(0, 32'h0, 10'h0);
    end

    // Up press/release, 3 clk latency and one-cycle pulse
    key(1'b1, 1'b1, 8'h75);
    expect_at(3, 32'h008, 10'h008);
    expect_at(4, 32'h008, 10'h000);
    repeat (5) step();
    key(1'b0, 1'b1, 8'h75);
    expect_at(3, 32'h0, 10'h0);
    repeat (5) step();

    // Left, right, release right: last input wins, left reasserts
    key(1'b1, 1'b1, 8'h6B);
    expect_at(3, 32'h002, 10'h002);
    step();
    key(1'b1, 1'b1, 8'h74);
    expect_at(3, 32'h001, 10'h001);
    step();
    key(1'b0, 1'b1, 8'h74);
    expect_at(3, 32'h002, 10'h002);
    expect_at(4, 32'h002, 10'h000);
    repeat (5) step();
    key(1'b0, 1'b1, 8'h6B);
    expect_at(3, 32'h0, 10'h0);
    repeat (5) step();

    // Joystick merge and E0 flag mismatch
    joystick_in = 32'h010;
    expect_at(1, 32'h010, 10'h010);
    repeat (2) step();
    key(1'b1, 1'b0, 8'h5A);
    expect_at(3, 32'h110, 10'h100);
    repeat (4) step();
    key(1'b0, 1'b0, 8'h5A);
    expect_at(3, 32'h010, 10'h000);
    repeat (4) step();
    key(1'b1, 1'b1, 8'h5A);
    expect_at(3, 32'h010, 10'h000);
    expect_at(4, 32'h010, 10'h000);
    repeat (4) step();
    key(1'b0, 1'b1, 8'h5A);
    repeat (4) step();
    joystick_in = 32'h0;
    expect_at(1, 32'h0, 10'h0);
    repeat (2) step();

    // Hold Z, open OSD: state clears, joystick still passes, release during OSD is consumed
    key(1'b1, 1'b0, 8'h1A);
    expect_at(3, 32'h010, 10'h010);
    repeat (4) step();
    osd_status = 1'b1;
    expect_at(1, 32'h010, 10'h000);
    expect_at(2, 32'h000, 10'h000);
    repeat (2) step();
    joystick_in = 32'h020;
    expect_at(1, 32'h020, 10'h020);
    repeat (2) step();
    joystick_in = 32'h0;
    expect_at(1, 32'h0, 10'h0);
    step();
    key(1'b0, 1'b0, 8'h1A);
    expect_at(3, 32'h0, 10'h0);
    repeat (4) step();
    osd_status = 1'b0;
    expect_at(1, 32'h0, 10'h0);
    expect_at(3, 32'h0, 10'h0);
    repeat (4) step();

    // Event decoded in the same cycle OSD closes is applied
    osd_status = 1'b1;
    repeat (2) step();
    key(1'b1, 1'b0, 8'h22);
    step();
    osd_status = 1'b0;
    expect_at(2, 32'h020, 10'h020);
    repeat (4) step();
    key(1'b0, 1'b0, 8'h22);
    expect_at(3, 32'h0, 10'h0);
    repeat (4) step();

    // Reset mid-keypress: key stays released afterwards
    key(1'b1, 1'b0, 8'h1A);
    expect_at(3, 32'h010, 10'h010);
    repeat (4) step();
    reset_n = 1'b0;
    expect_at(0, 32'h0, 10'h0);
    step();
    expect_at(0, 32'h0, 10'h0);
    step();
    reset_n = 1'b1;
    repeat (5) begin
      step();
      expect_at(0, 32'h0, 10'h0);
    end
    key(1'b0, 1'b0, 8'h1A);
    expect_at(3, 32'h0, 10'h0);
    repeat (4) step();

    // Ten toggles on consecutive clocks
    for (int i = 0; i < 10; i++) begin
      key(tbl[i].p, tbl[i].e0, tbl[i].code);
      expect_at(3, tbl[i].jo, tbl[i].jp);
      step();
    end
    expect_at(5, 32'h2C4, 10'h000);
    repeat (8) step();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
